// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder: one full-adder slice and a carry flop, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               c_out_q, c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic               s_bit;
    logic               carry_nxt;
    logic [WIDTH-1:0]   res_nxt;

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    always_comb begin
        s_bit     = a_q[0] ^ b_q[0] ^ carry_q;
        carry_nxt = maj3(a_q[0], b_q[0], carry_q);
        // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts.
        res_nxt   = (res_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        c_out_d = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_SHIFT;
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    carry_d = c_in;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                res_d   = res_nxt;
                carry_d = carry_nxt;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = res_nxt;
                    c_out_d = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                    // On the last slice carry_q is the carry into the MSB.
                    ovf_d   = carry_q ^ carry_nxt;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed bench for serial_adder_n at WIDTH=8, 2 and 1; ovf cases when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_n;

    logic       clk;
    logic       rst;

    logic       start8, cin8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;
    logic       start1, cin1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf2, ovf1;
`endif

    int tests_run = 0;
    int fails = 0;

    serial_adder_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .c_in(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder_n #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c_in(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .c_out(cout2)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf2)
`endif
    );

    serial_adder_n #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .c_in(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Start one WIDTH=8 add, scramble the inputs during SHIFT, observe 14 cycles from the accept edge.
    task automatic do_add8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                           output logic [7:0] s, output logic co,
                           output int done_at, output int busy_n, output int done_n);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        s = 'x; co = 1'bx; done_at = -1; busy_n = 0; done_n = 0;
        for (int i = 0; i < 14; i++) begin
            if (i > 0) tick;
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (done_at < 0) done_at = i;
                s = sum8;
                co = cout8;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick;
        tick;
        tests_run++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy8); end
        tests_run++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", done8); end
        tests_run++; if (sum8 !== 8'h00) begin fails++; $display("FAIL reset_sum got %h exp 00", sum8); end
        tests_run++; if (cout8 !== 1'b0) begin fails++; $display("FAIL reset_cout got %b exp 0", cout8); end
`ifdef SERIAL_ADDER_OVF_EN
        tests_run++; if (ovf8 !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", ovf8); end
`endif
        // rst and start on the same edge: reset must win
        start8 = 1'b1;
        tick;
        rst = 1'b0;
        start8 = 1'b0;
        tests_run++; if (busy8 !== 1'b0) begin fails++; $display("FAIL rst_start_busy got %b exp 0", busy8); end
        tick;
        tests_run++; if (busy8 !== 1'b0) begin fails++; $display("FAIL rst_start_after got %b exp 0", busy8); end
    endtask

    task automatic test_basic;
        logic [7:0] s; logic co; int at, bn, dn;
        do_add8(8'h5A, 8'h3C, 1'b0, s, co, at, bn, dn);
        tests_run++; if (s !== 8'h96) begin fails++; $display("FAIL basic_sum got %h exp 96", s); end
        tests_run++; if (co !== 1'b0) begin fails++; $display("FAIL basic_cout got %b exp 0", co); end
        tests_run++; if (at !== 8) begin fails++; $display("FAIL basic_done_cycle got %0d exp 8", at); end
        tests_run++; if (bn !== 8) begin fails++; $display("FAIL basic_busy_cycles got %0d exp 8", bn); end
        tests_run++; if (dn !== 1) begin fails++; $display("FAIL basic_done_count got %0d exp 1", dn); end
        tests_run++; if (sum8 !== 8'h96) begin fails++; $display("FAIL basic_sum_hold got %h exp 96", sum8); end
    endtask

    task automatic test_ignore_start;
        logic [7:0] s; logic co; int at, dn;
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick;
        tick;
        a8 = 8'hFF; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tests_run++; if (sum8 !== 8'h96) begin fails++; $display("FAIL ign_sum_stable got %h exp 96", sum8); end
        tests_run++; if (busy8 !== 1'b1) begin fails++; $display("FAIL ign_busy got %b exp 1", busy8); end
        s = 'x; co = 1'bx; at = -1; dn = 0;
        for (int i = 4; i <= 14; i++) begin
            tick;
            if (done8) begin
                dn++;
                if (at < 0) at = i;
                s = sum8;
                co = cout8;
            end
        end
        tests_run++; if (s !== 8'h03) begin fails++; $display("FAIL ign_sum got %h exp 03", s); end
        tests_run++; if (co !== 1'b0) begin fails++; $display("FAIL ign_cout got %b exp 0", co); end
        tests_run++; if (at !== 8) begin fails++; $display("FAIL ign_done_cycle got %0d exp 8", at); end
        tests_run++; if (dn !== 1) begin fails++; $display("FAIL ign_done_count got %0d exp 1", dn); end
    endtask

    task automatic test_wrap;
        logic [7:0] s; logic co; int at, bn, dn;
        do_add8(8'hFF, 8'h00, 1'b1, s, co, at, bn, dn);
        tests_run++; if (s !== 8'h00) begin fails++; $display("FAIL wrap_sum got %h exp 00", s); end
        tests_run++; if (co !== 1'b1) begin fails++; $display("FAIL wrap_cout got %b exp 1", co); end
        do_add8(8'hA5, 8'h5B, 1'b1, s, co, at, bn, dn);
        tests_run++; if ({co, s} !== 9'h101) begin fails++; $display("FAIL mix_result got %h exp 101", {co, s}); end
    endtask

    task automatic test_abort;
        logic [7:0] s; logic co; int at, bn, dn;
        a8 = 8'h77; b8 = 8'h11; cin8 = 1'b1; start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tests_run++; if (busy8 !== 1'b0) begin fails++; $display("FAIL abort_busy got %b exp 0", busy8); end
        tests_run++; if (done8 !== 1'b0) begin fails++; $display("FAIL abort_done got %b exp 0", done8); end
        tests_run++; if (sum8 !== 8'h00) begin fails++; $display("FAIL abort_sum got %h exp 00", sum8); end
        tests_run++; if (cout8 !== 1'b0) begin fails++; $display("FAIL abort_cout got %b exp 0", cout8); end
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done8) dn++;
        end
        tests_run++; if (dn !== 0) begin fails++; $display("FAIL abort_no_done got %0d exp 0", dn); end
        do_add8(8'h12, 8'h34, 1'b1, s, co, at, bn, dn);
        tests_run++; if ({co, s} !== 9'h047) begin fails++; $display("FAIL abort_restart got %h exp 047", {co, s}); end
        tests_run++; if (at !== 8) begin fails++; $display("FAIL abort_restart_cycle got %0d exp 8", at); end
    endtask

    task automatic test_back_to_back;
        int nd;
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        tick;
        nd = 0;
        for (int i = 1; i <= 28; i++) begin
            tick;
            if (done8) begin
                tests_run++; if (i !== 8 + 9 * nd) begin fails++; $display("FAIL b2b_done_cycle got %0d exp %0d", i, 8 + 9 * nd); end
                tests_run++; if (sum8 !== 8'h30 + 8'(nd)) begin fails++; $display("FAIL b2b_sum got %h exp %h", sum8, 8'h30 + 8'(nd)); end
                nd++;
                a8 = a8 + 8'h01;
            end
        end
        tests_run++; if (nd !== 3) begin fails++; $display("FAIL b2b_done_count got %0d exp 3", nd); end
        start8 = 1'b0;
        for (int i = 0; i < 12; i++) tick;
    endtask

    task automatic test_width2;
        logic [2:0] obs, exp_v;
        for (int ia = 0; ia < 4; ia++) begin
            for (int ib = 0; ib < 4; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a2 = 2'(ia); b2 = 2'(ib); cin2 = 1'(ic); start2 = 1'b1;
                    tick;
                    start2 = 1'b0;
                    obs = 'x;
                    for (int i = 1; i <= 5; i++) begin
                        tick;
                        if (done2 && i == 2) obs = {cout2, sum2};
                    end
                    exp_v = 3'(ia + ib + ic);
                    tests_run++; if (obs !== exp_v) begin fails++; $display("FAIL w2_%0d_%0d_%0d got %b exp %b", ia, ib, ic, obs, exp_v); end
                end
            end
        end
    endtask

    task automatic test_width1;
        logic [1:0] obs, exp_v;
        logic       b0;
        for (int ia = 0; ia < 2; ia++) begin
            for (int ib = 0; ib < 2; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a1 = 1'(ia); b1 = 1'(ib); cin1 = 1'(ic); start1 = 1'b1;
                    tick;
                    start1 = 1'b0;
                    b0 = busy1;
                    obs = 'x;
                    for (int i = 1; i <= 4; i++) begin
                        tick;
                        if (done1 && i == 1) obs = {cout1, sum1};
                    end
                    exp_v = 2'(ia + ib + ic);
                    tests_run++; if (obs !== exp_v) begin fails++; $display("FAIL w1_%0d_%0d_%0d got %b exp %b", ia, ib, ic, obs, exp_v); end
                    tests_run++; if (b0 !== 1'b1) begin fails++; $display("FAIL w1_busy got %b exp 1", b0); end
                end
            end
        end
    endtask

`ifdef SERIAL_ADDER_OVF_EN
    task automatic test_ovf;
        logic [7:0] s; logic co; int at, bn, dn;
        do_add8(8'h7F, 8'h01, 1'b0, s, co, at, bn, dn);
        tests_run++; if (ovf8 !== 1'b1) begin fails++; $display("FAIL ovf_7f_01 got %b exp 1", ovf8); end
        tests_run++; if (s !== 8'h80) begin fails++; $display("FAIL ovf_7f_01_sum got %h exp 80", s); end
        do_add8(8'hFF, 8'h01, 1'b0, s, co, at, bn, dn);
        tests_run++; if (ovf8 !== 1'b0) begin fails++; $display("FAIL ovf_ff_01 got %b exp 0", ovf8); end
        do_add8(8'h80, 8'h80, 1'b0, s, co, at, bn, dn);
        tests_run++; if (ovf8 !== 1'b1) begin fails++; $display("FAIL ovf_80_80 got %b exp 1", ovf8); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        test_reset;
        test_basic;
        test_ignore_start;
        test_wrap;
        test_abort;
        test_back_to_back;
        test_width2;
        test_width1;
`ifdef SERIAL_ADDER_OVF_EN
        test_ovf;
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
